// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache miss path: geometry
// constants and the refill engine state encoding.
package icache_pkg;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int WADDR_W    = ADDR_W - 2;
  localparam int MEM_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/icache_refill_ctrl_lat_pipe.sv
// Fixed-latency token pipe: a grant enters at the head and emerges DEPTH
// cycles later, marking the cycle in which the memory read data is valid.
module lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic tok_in,
  output logic tok_out
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  // Each stage takes the previous one; the head takes the incoming token.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = tok_in;
      end else begin : g_body
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  // Advance all stages together; reset drops every token in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign tok_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Line refill engine: accepts one miss at a time, reads the line from a
// fixed-latency memory in critical-word-first wrap order and streams each
// word back to the cache as it arrives.
module icache_refill_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req,
  input  logic [ADDR_W-1:0] c_addr,
  output logic              ack,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata
);

  import icache_pkg::*;

  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int WA_W  = ADDR_W - 2;
  localparam int CNT_W = OFS_W + 1;

  state_t           state_reg;
  logic [OFS_W-1:0] off0_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] returned_reg;
  logic             grant;
  logic             capture;
  logic [OFS_W-1:0] next_off;

  // A grant only counts while a read is actually being requested.
  assign grant = mem_rd & mem_gnt;

  // Offset of the word after the one just granted; wraps within the line.
  assign next_off = off0_reg + issued_reg[OFS_W-1:0] + OFS_W'(1);

  lat_pipe #(
    .DEPTH (MEM_LAT)
  ) u_lat_pipe (
    .clk     (hclk),
    .srst    (hreset),
    .tok_in  (grant),
    .tok_out (capture)
  );

  // Refill sequencing, read issue and word return, all outputs registered.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg    <= IDLE;
      ack          <= 1'b0;
      valid        <= 1'b0;
      data         <= '0;
      busy         <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      off0_reg     <= '0;
      issued_reg   <= '0;
      returned_reg <= '0;
    end else begin
      ack   <= 1'b0;
      valid <= 1'b0;

      // Tokens only exist between acceptance and the last return.
      if (capture) begin
        data         <= mem_rdata;
        valid        <= 1'b1;
        returned_reg <= returned_reg + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (req) begin
            ack          <= 1'b1;
            busy         <= 1'b1;
            mem_rd       <= 1'b1;
            mem_addr     <= c_addr[ADDR_W-1:2];
            off0_reg     <= c_addr[OFS_W+1:2];
            issued_reg   <= '0;
            returned_reg <= '0;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            issued_reg <= issued_reg + CNT_W'(1);
            mem_addr   <= {mem_addr[WA_W-1:OFS_W], next_off};
            if (issued_reg == CNT_W'(LINE_WORDS - 1)) begin
              mem_rd    <= 1'b0;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (returned_reg == CNT_W'(LINE_WORDS)) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for the line refill engine: directed scenarios followed by random
// request/grant/reset traffic, checked against a queue-based model of the
// refill protocol.
module tb_icache_refill_ctrl;

  localparam int MEM_LAT    = 2;
  localparam int LINE_WORDS = 4;

  logic        hclk;
  logic        hreset;
  logic        req;
  logic [19:0] c_addr;
  logic        ack;
  logic        valid;
  logic [31:0] data;
  logic        busy;
  logic        mem_rd;
  logic [17:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;

  icache_refill_ctrl #(
    .ADDR_W     (20),
    .DATA_W     (32),
    .LINE_WORDS (LINE_WORDS),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .req       (req),
    .c_addr    (c_addr),
    .ack       (ack),
    .valid     (valid),
    .data      (data),
    .busy      (busy),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Inputs applied during the cycle just left.
  logic        req_p, gnt_p, rst_p;
  logic [19:0] addr_p;

  // Memory responder history: grants seen per cycle.
  logic        gh_v [8];
  logic [17:0] gh_a [8];

  // Reference model state.
  typedef struct {
    int          due;
    logic [17:0] a;
  } ret_t;

  logic [17:0] iss_q [$];
  ret_t        ret_q [$];
  bit          m_active;
  bit          m_ack;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_beats;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {a[13:0], ~a} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one cycle from the inputs of the previous cycle.
  task automatic model_step();
    bit   was_active;
    bit   last_prev;
    ret_t r;
    was_active = m_active;
    last_prev  = m_valid && (m_beats == LINE_WORDS);
    if (rst_p) begin
      m_active = 0;
      m_ack    = 0;
      m_valid  = 0;
      m_data   = '0;
      m_beats  = 0;
      iss_q.delete();
      ret_q.delete();
      return;
    end
    m_ack   = 0;
    m_valid = 0;
    if (iss_q.size() > 0 && gnt_p) begin
      r.due = cyc + MEM_LAT;
      r.a   = iss_q.pop_front();
      ret_q.push_back(r);
    end
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      m_valid = 1;
      m_data  = mem_word(ret_q[0].a);
      void'(ret_q.pop_front());
      m_beats++;
    end
    if (was_active && last_prev) begin
      m_active = 0;
    end else if (!was_active && req_p) begin
      m_active = 1;
      m_ack    = 1;
      m_beats  = 0;
      for (int k = 0; k < LINE_WORDS; k++)
        iss_q.push_back({addr_p[19:4], 2'(int'(addr_p[3:2]) + k)});
    end
  endtask

  task automatic check_outputs();
    bit exp_rd;
    exp_rd = m_active && (iss_q.size() > 0);
    chk("ack", ack, m_ack);
    chk("valid", valid, m_valid);
    chk("data", data, m_data);
    chk("busy", busy, m_active);
    chk("mem_rd", mem_rd, exp_rd);
    if (exp_rd) chk("mem_addr", mem_addr, iss_q[0]);
    if (rst_p) chk("mem_addr_rst", mem_addr, 0);
  endtask

  // Apply inputs for the current cycle, answer the memory, then move on
  // one clock and check the new outputs against the model.
  task automatic cycle(input logic r, input logic [19:0] a, input logic g, input logic rs);
    int slot;
    int src;
    req     = r;
    c_addr  = a;
    mem_gnt = g;
    hreset  = rs;
    slot = cyc % 8;
    gh_v[slot] = mem_rd & mem_gnt;
    gh_a[slot] = mem_addr;
    src = (cyc + 8 - MEM_LAT) % 8;
    if (cyc >= MEM_LAT && gh_v[src] === 1'b1) mem_rdata = mem_word(gh_a[src]);
    else mem_rdata = $urandom;
    req_p  = r;
    addr_p = a;
    gnt_p  = g;
    rst_p  = rs;
    @(posedge hclk);
    #1;
    cyc++;
    model_step();
    check_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_active && n < 40) begin
      cycle(1'b0, 20'h0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  logic [17:0] crit_exp [4];
  logic        r_rand;
  logic        g_rand;
  logic        s_rand;
  logic [19:0] a_rand;

  initial begin
    for (int i = 0; i < 8; i++) begin
      gh_v[i] = 1'b0;
      gh_a[i] = '0;
    end
    m_active = 0; m_ack = 0; m_valid = 0; m_data = '0; m_beats = 0;
    req = 0; c_addr = '0; mem_gnt = 0; hreset = 1; mem_rdata = '0;

    cycle(1'b0, 20'h0, 1'b0, 1'b1);
    cycle(1'b0, 20'h0, 1'b0, 1'b1);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);

    // Aligned refill, memory always granting.
    cycle(1'b1, 20'h01230, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) chk("aln_addr", mem_addr, 32'(18'h048C + k - 1));
      if (k >= 4 && k <= 7) chk("aln_data", data, mem_word(18'(32'h048C + k - 4)));
      chk("aln_valid", valid, (k >= 4 && k <= 7));
      chk("aln_busy", busy, (k <= 7));
      cycle(1'b0, 20'h01230, 1'b1, 1'b0);
    end
    drain();

    // Critical word in the last slot of the line.
    crit_exp = '{18'h048F, 18'h048C, 18'h048D, 18'h048E};
    cycle(1'b1, 20'h0123C, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) chk("crit_addr", mem_addr, crit_exp[k-1]);
      if (k >= 4) chk("crit_data", data, mem_word(crit_exp[k-4]));
      cycle(1'b0, 20'h0123C, 1'b1, 1'b0);
    end
    drain();

    // Grant withheld in cycles 2 and 3.
    cycle(1'b1, 20'h01230, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k >= 2 && k <= 4) chk("stl_addr", mem_addr, 18'h048D);
      chk("stl_valid", valid, (k == 4 || (k >= 7 && k <= 9)));
      cycle(1'b0, 20'h01230, !(k == 2 || k == 3), 1'b0);
    end
    drain();

    // Request held high across the whole refill.
    cycle(1'b1, 20'h01230, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      chk("hold_ack", ack, (k == 1 || k == 9));
      cycle(1'b1, 20'h01230, 1'b1, 1'b0);
    end
    drain();

    // Reset in cycle 3 of a refill; late memory data must be dropped.
    cycle(1'b1, 20'h01230, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k >= 4) chk("mrst_valid", valid, 0);
      if (k == 4) begin
        chk("mrst_busy", busy, 0);
        chk("mrst_rd", mem_rd, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_data", data, 0);
        chk("mrst_ack", ack, 0);
      end
      cycle(1'b0, 20'h01230, 1'b1, (k == 3));
    end
    cycle(1'b1, 20'h0123C, 1'b1, 1'b0);
    chk("post_rst_ack", ack, 1);
    chk("post_rst_addr", mem_addr, 18'h048F);
    drain();

    // Random traffic: requests, grants, addresses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r_rand = ($urandom_range(0, 2) != 0);
      g_rand = ($urandom_range(0, 3) != 0);
      s_rand = ($urandom_range(0, 199) == 0);
      a_rand = 20'($urandom);
      cycle(r_rand, a_rand, g_rand, s_rand);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
